pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-003 SHALL have port opcode, input, 4, instruction opcode from IR; stable from DECODE until instruction end.
REQ-004 SHALL have port zero, input, 1, ALU zero flag; sampled only in EXEC.
REQ-005 SHALL have port memReady, input, 1, memory completion handshake.
REQ-006 SHALL have outputs writeIR, writePC, writeRA, PCsrc, ImRPC, conditionalBop, memRead, memWrite, regWrite, illegal, each 1 bit, as strobes/selects for the program-counting datapath and memory/regfile.
REQ-007 SHALL have port state, output, 3, current FSM state encoding.
REQ-008 SHALL have port instrCount, output, 16, retired-instruction counter.

Function
REQ-009 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; codes 6-7 unreachable and SHALL go to FETCH next cycle with all strobes 0.
REQ-010 SHALL decode opcode: 0 ALU-R, 1 ALU-I, 2 load, 3 store, 4 jump, 5 jal, 6 jr, 7 beq, 8 bne, F halt; 9-E illegal.
REQ-011 SHALL decode all outputs combinationally from state, opcode, zero, memReady; unlisted outputs 0 in every state.
REQ-012 FETCH: memRead=1; stay while memReady=0; on memReady=1 assert writeIR=1 same cycle, go DECODE.
REQ-013 DECODE, jump: writePC=1, ImRPC=1, PCsrc=0 -> FETCH.
REQ-014 DECODE, jal: writePC=1, writeRA=1, ImRPC=1, PCsrc=0 -> FETCH; RA captures old PC+1 on same edge.
REQ-015 DECODE, jr: writePC=1, PCsrc=1 -> FETCH.
REQ-016 DECODE, halt: no strobes -> HALT; HALT holds all strobes 0 until reset.
REQ-017 DECODE, illegal: writePC=1 (PC+1 path), illegal=1 for that single cycle -> FETCH.
REQ-018 DECODE, ALU/load/store/branch: no strobes -> EXEC.
REQ-019 EXEC, ALU-R/ALU-I: -> WB. EXEC, load/store: -> MEM.
REQ-020 EXEC, beq: writePC=1, conditionalBop=zero; bne: writePC=1, conditionalBop=~zero; both -> FETCH.
REQ-021 MEM: load asserts memRead=1, store asserts memWrite=1; hold state while memReady=0; on memReady=1 load -> WB, store asserts writePC=1 -> FETCH.
REQ-022 WB: regWrite=1, writePC=1 -> FETCH.
REQ-023 writePC SHALL assert exactly once per retired instruction; ImRPC and conditionalBop SHALL never both be 1.
REQ-024 instrCount SHALL increment by 1 on every cycle with writePC=1, modulo 2^16 (0xFFFF -> 0x0000).
REQ-025 Latencies (memReady=1 immediately): jump/jal/jr/illegal 2 cycles; branch 3; ALU and store 4; load 5.

Reset
REQ-026 While reset=1 all combinational outputs SHALL be forced 0 regardless of state.
REQ-027 On clock edge with reset=1: state=FETCH, instrCount=0x0000; takes priority over every transition, including mid-MEM-wait and HALT.
REQ-028 First cycle after reset deassertion SHALL be FETCH with memRead=1.

Verification
REQ-029 Reset, memReady=1, opcode=0: states 0,1,2,4,0; writeIR in cycle 1, regWrite+writePC in cycle 4; instrCount=1.
REQ-030 opcode=7, zero=1 -> EXEC cycle writePC=1, conditionalBop=1; repeat with zero=0 -> conditionalBop=0; opcode=8 inverts both.
REQ-031 opcode=5 -> DECODE cycle writePC=writeRA=ImRPC=1, PCsrc=0; then opcode=6 -> PCsrc=1, ImRPC=0.
REQ-032 Load with memReady held 0 for 3 cycles in MEM -> memRead=1 held 3 cycles, no writePC; memReady=1 -> WB next.
REQ-033 opcode=F -> HALT, strobes 0 for 10 cycles; reset=1 one cycle -> FETCH, instrCount=0.
REQ-034 Preload instrCount to 0xFFFF via 65535 jumps, one more jump -> 0x0000; opcode=0xA -> illegal=1 one cycle, instrCount+1.

Source files
------------

// File: rtl/pc_sequencer.sv
// Control FSM for the program-counting datapath: fetch/decode/exec/mem/wb with a retired-instruction counter.
// Strobes are decoded combinationally from the current state and inputs; memReady stalls FETCH and MEM.
module pc_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  opcode,
    input  logic        zero,
    input  logic        memReady,
    output logic        writeIR,
    output logic        writePC,
    output logic        writeRA,
    output logic        PCsrc,
    output logic        ImRPC,
    output logic        conditionalBop,
    output logic        memRead,
    output logic        memWrite,
    output logic        regWrite,
    output logic        illegal,
    output logic [2:0]  state,
    output logic [15:0] instrCount
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    logic [2:0]  r_state;
    logic [2:0]  w_next;
    logic [15:0] r_count;

    logic w_op_alu, w_op_load, w_op_store, w_op_jump, w_op_jal, w_op_jr;
    logic w_op_beq, w_op_bne, w_op_branch, w_op_halt, w_op_illegal;

    assign w_op_alu     = (opcode == 4'h0) || (opcode == 4'h1);
    assign w_op_load    = (opcode == 4'h2);
    assign w_op_store   = (opcode == 4'h3);
    assign w_op_jump    = (opcode == 4'h4);
    assign w_op_jal     = (opcode == 4'h5);
    assign w_op_jr      = (opcode == 4'h6);
    assign w_op_beq     = (opcode == 4'h7);
    assign w_op_bne     = (opcode == 4'h8);
    assign w_op_branch  = w_op_beq || w_op_bne;
    assign w_op_halt    = (opcode == 4'hF);
    assign w_op_illegal = (opcode >= 4'h9) && (opcode <= 4'hE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_count <= 16'h0000;
        end else begin
            r_state <= w_next;
            if (writePC) begin
                r_count <= r_count + 16'd1;
            end
        end
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = memReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (w_op_halt) begin
                    w_next = S_HALT;
                end else if (w_op_alu || w_op_load || w_op_store || w_op_branch) begin
                    w_next = S_EXEC;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_EXEC: begin
                if (w_op_alu) begin
                    w_next = S_WB;
                end else if (w_op_load || w_op_store) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_MEM: begin
                if (!memReady) begin
                    w_next = S_MEM;
                end else if (w_op_load) begin
                    w_next = S_WB;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_WB:    w_next = S_FETCH;
            S_HALT:  w_next = S_HALT;
            default: w_next = S_FETCH;
        endcase
    end

    // Reset gates every strobe so the counter cannot advance while held in reset.
    always_comb begin
        writeIR        = 1'b0;
        writePC        = 1'b0;
        writeRA        = 1'b0;
        PCsrc          = 1'b0;
        ImRPC          = 1'b0;
        conditionalBop = 1'b0;
        memRead        = 1'b0;
        memWrite       = 1'b0;
        regWrite       = 1'b0;
        illegal        = 1'b0;
        if (!reset) begin
            case (r_state)
                S_FETCH: begin
                    memRead = 1'b1;
                    writeIR = memReady;
                end
                S_DECODE: begin
                    if (w_op_jump || w_op_jal) begin
                        writePC = 1'b1;
                        ImRPC   = 1'b1;
                        writeRA = w_op_jal;
                    end else if (w_op_jr) begin
                        writePC = 1'b1;
                        PCsrc   = 1'b1;
                    end else if (w_op_illegal) begin
                        writePC = 1'b1;
                        illegal = 1'b1;
                    end
                end
                S_EXEC: begin
                    if (w_op_branch) begin
                        writePC        = 1'b1;
                        conditionalBop = w_op_beq ? zero : ~zero;
                    end
                end
                S_MEM: begin
                    memRead  = w_op_load;
                    memWrite = w_op_store;
                    writePC  = w_op_store && memReady;
                end
                S_WB: begin
                    regWrite = 1'b1;
                    writePC  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state      = r_state;
    assign instrCount = r_count;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized bench for pc_sequencer: the stimulus side queues an expected retirement per instruction,
// a negedge monitor pops and compares on every writePC strobe.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  opcode = 4'h0;
    logic        zero = 1'b0;
    logic        memReady = 1'b0;
    logic        writeIR, writePC, writeRA, PCsrc, ImRPC, conditionalBop;
    logic        memRead, memWrite, regWrite, illegal;
    logic [2:0]  state;
    logic [15:0] instrCount;

    pc_sequencer dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .memReady(memReady),
        .writeIR(writeIR), .writePC(writePC), .writeRA(writeRA), .PCsrc(PCsrc), .ImRPC(ImRPC),
        .conditionalBop(conditionalBop), .memRead(memRead), .memWrite(memWrite),
        .regWrite(regWrite), .illegal(illegal), .state(state), .instrCount(instrCount)
    );

    always #5 clk = ~clk;

    // strobe vector layout: {writeIR, writeRA, PCsrc, ImRPC, conditionalBop, memRead, memWrite, regWrite, illegal}
    localparam int B_IR = 8, B_RA = 7, B_PCS = 6, B_IMR = 5, B_CB = 4, B_MRD = 3, B_MWR = 2, B_RW = 1, B_ILL = 0;

    typedef struct {
        logic [3:0]  op;
        int          cycles;
        logic [63:0] trace;
        int          nrd;
        int          nwr;
        int          nir;
        logic [8:0]  strb;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          n_total = 0;
    int          n_bad = 0;
    logic [15:0] m_count = 16'h0000;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Phase list per instruction class; memReady low for fw FETCH cycles and mw MEM cycles.
    function automatic exp_t model(input logic [3:0] op, input logic z, input int fw, input int mw,
                                   input logic [15:0] cnt);
        exp_t e;
        int   ph[$];
        e.op = op; e.cnt = cnt; e.strb = '0; e.trace = '0; e.nir = 1;
        e.nrd = fw + 1; e.nwr = 0;
        for (int i = 0; i <= fw; i++) ph.push_back(0);
        ph.push_back(1);
        case (op)
            4'h0, 4'h1: begin ph.push_back(2); ph.push_back(4); e.strb[B_RW] = 1'b1; end
            4'h2: begin
                ph.push_back(2);
                for (int i = 0; i <= mw; i++) ph.push_back(3);
                ph.push_back(4);
                e.nrd = e.nrd + mw + 1;
                e.strb[B_RW] = 1'b1;
            end
            4'h3: begin
                ph.push_back(2);
                for (int i = 0; i <= mw; i++) ph.push_back(3);
                e.nwr = mw + 1;
                e.strb[B_MWR] = 1'b1;
            end
            4'h4: e.strb[B_IMR] = 1'b1;
            4'h5: begin e.strb[B_IMR] = 1'b1; e.strb[B_RA] = 1'b1; end
            4'h6: e.strb[B_PCS] = 1'b1;
            4'h7: begin ph.push_back(2); e.strb[B_CB] = z; end
            4'h8: begin ph.push_back(2); e.strb[B_CB] = !z; end
            default: e.strb[B_ILL] = 1'b1;
        endcase
        e.cycles = ph.size();
        foreach (ph[i]) e.trace = {e.trace[60:0], 3'(ph[i])};
        return e;
    endfunction

    task automatic run_instr(input logic [3:0] op, input logic z, input int fw, input int mw);
        exp_t e;
        e = model(op, z, fw, mw, m_count);
        sb.push_back(e);
        m_count = m_count + 16'd1;
        opcode = op;
        zero = z;
        for (int k = 0; k < e.cycles; k++) begin
            memReady = !((k < fw) || ((k >= fw + 3) && (k < fw + 3 + mw)));
            @(posedge clk); #1;
        end
        memReady = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        memReady = 1'b1;
        opcode = 4'h4;
        repeat (n) begin @(posedge clk); #1; end
        reset = 1'b0;
        memReady = 1'b0;
        m_count = 16'h0000;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) begin @(posedge clk); #1; end
        check("scoreboard_drain", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    // Monitor: accumulates per-instruction activity and compares at each retirement.
    int          a_cyc, a_rd, a_wr, a_ir;
    logic [63:0] a_tr;
    bit          after_rst;
    logic [8:0]  m_strb;
    exp_t        m_e;

    always @(negedge clk) begin
        m_strb = {writeIR, writeRA, PCsrc, ImRPC, conditionalBop, memRead, memWrite, regWrite, illegal};
        if (reset) begin
            check("reset_strobes", {m_strb, writePC}, 64'd0);
            a_cyc = 0; a_rd = 0; a_wr = 0; a_ir = 0; a_tr = '0;
            after_rst = 1'b1;
        end else begin
            if (after_rst) begin
                check("post_reset_state", state, 64'd0);
                check("post_reset_memRead", memRead, 64'd1);
                check("post_reset_count", instrCount, 64'd0);
                after_rst = 1'b0;
            end
            check("imrpc_cbop_exclusive", ImRPC & conditionalBop, 64'd0);
            a_cyc++;
            a_tr = {a_tr[60:0], state};
            a_rd += int'(memRead);
            a_wr += int'(memWrite);
            a_ir += int'(writeIR);
            if (writePC) begin
                if (sb.size() == 0) begin
                    n_total++;
                    n_bad++;
                    $display("FAIL spurious_writePC actual=1 expected=0 state=%0d (t=%0t)", state, $time);
                end else begin
                    m_e = sb.pop_front();
                    check("latency_cycles", 64'(a_cyc), 64'(m_e.cycles));
                    check("state_trace", a_tr, m_e.trace);
                    check("memRead_cycles", 64'(a_rd), 64'(m_e.nrd));
                    check("memWrite_cycles", 64'(a_wr), 64'(m_e.nwr));
                    check("writeIR_cycles", 64'(a_ir), 64'(m_e.nir));
                    check("retire_strobes", m_strb, m_e.strb);
                    check("instrCount", instrCount, m_e.cnt);
                end
                a_cyc = 0; a_rd = 0; a_wr = 0; a_ir = 0; a_tr = '0;
            end
        end
    end

    initial begin
        #4_000_000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] op;
        do_reset(2);

        run_instr(4'h0, 1'b0, 0, 0);
        run_instr(4'h7, 1'b1, 0, 0);
        run_instr(4'h7, 1'b0, 0, 0);
        run_instr(4'h8, 1'b1, 0, 0);
        run_instr(4'h8, 1'b0, 0, 0);
        run_instr(4'h5, 1'b0, 0, 0);
        run_instr(4'h6, 1'b0, 0, 0);
        run_instr(4'h2, 1'b0, 0, 3);
        run_instr(4'h3, 1'b1, 1, 2);
        run_instr(4'h1, 1'b1, 2, 0);

        for (int i = 0; i < 400; i++) begin
            op = 4'($urandom_range(0, 14));
            run_instr(op, 1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
        drain();

        // Counter wrap: 65535 jumps reach 0xFFFF, the next one wraps to 0.
        do_reset(1);
        for (int i = 0; i < 65536; i++) run_instr(4'h4, 1'b0, 0, 0);
        run_instr(4'hA, 1'b0, 0, 0);
        drain();
        @(negedge clk);
        check("count_after_wrap_illegal", instrCount, 64'(m_count));
        @(posedge clk); #1;

        // Reset while waiting in MEM.
        do_reset(1);
        opcode = 4'h2;
        memReady = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        memReady = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        check("mem_wait_state", state, 64'd3);
        check("mem_wait_memRead", memRead, 64'd1);
        @(posedge clk); #1;
        do_reset(1);

        // Halt holds with no strobes until reset.
        opcode = 4'hF;
        memReady = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        for (int i = 0; i < 10; i++) begin
            memReady = 1'($urandom);
            zero = 1'($urandom);
            @(negedge clk);
            check("halt_state", state, 64'd5);
            check("halt_strobes", {writeIR, writeRA, PCsrc, ImRPC, conditionalBop, memRead,
                                   memWrite, regWrite, illegal, writePC}, 64'd0);
            check("halt_count", instrCount, 64'(m_count));
            @(posedge clk); #1;
        end
        do_reset(1);
        run_instr(4'h0, 1'b0, 0, 0);
        drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
